lfsr_rr_scheduler: RTL and testbench

Shares one Galois-free, shift-left XNOR LFSR among NREQ stimulus consumers, e.g. the random digit-stream feeders of the online-arithmetic operator testbenches. Requesters are served round-robin with a per-grant burst quota. The LFSR advances only when a word is actually delivered, so every consumer gets disjoint, reproducible draws. The block also handles run-time reseeding and rejects the lockup seed.

---
 rtl/lfsr_sched_pkg.sv | 22 ++
 rtl/lfsr_rr_scheduler_rr_pick.sv | 32 +++
 rtl/lfsr_rr_scheduler.sv | 161 ++++++++++++++++
 tb/tb_lfsr_rr_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_sched_pkg.sv
// lfsr_sched_pkg: shared types and constants for the LFSR round-robin scheduler.
package lfsr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    RESEED = 2'd2
  } sched_state_e;

  // Known-good XNOR feedback masks for common widths.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  localparam int LOCKUP_MAX = 256;

  // All-ones word of the given width: the XNOR LFSR's lockup state.
  function automatic logic [LOCKUP_MAX-1:0] lockup_word(input int width);
    return {LOCKUP_MAX{1'b1}} >> (LOCKUP_MAX - width);
  endfunction

endpackage

// File: rtl/lfsr_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// at or after i_ptr, searching cyclically, as one-hot, index and any-flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_pos;

  // Cyclic scan starting at the pointer; the first hit wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = IW'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: one shift-left XNOR LFSR shared round-robin among NREQ
// requesters with a per-grant burst quota; the LFSR steps only on delivery.
// Optional macro LFSR_SCHED_STATS_EN adds draw_count and per_req_hits.
//
// state  | meaning
// IDLE   | no grant last cycle; req grants now, seed_load goes to RESEED
// SERVE  | granted last cycle; keep granting while any req is set
// RESEED | load the sampled seed (all-ones replaced by SEED), then IDLE
module lfsr_rr_scheduler
  import lfsr_sched_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter int              NREQ  = 4,
  parameter int              BURST = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_W32),
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed_data,
  output logic                     seed_err,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic                     rnd_valid,
  output logic [WIDTH-1:0]         rnd_data,
  output logic [$clog2(NREQ)-1:0]  rnd_id,
  output logic                     busy
`ifdef LFSR_SCHED_STATS_EN
  ,
  output logic [31:0]              draw_count,
  output logic [NREQ-1:0][15:0]    per_req_hits
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST + 1);
  localparam logic [WIDTH-1:0] LOCKUP = WIDTH'(lockup_word(WIDTH));

  sched_state_e     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, r_seed_hold, w_lfsr_step;
  logic [IDW-1:0]   r_ptr, w_eff_ptr, w_win_idx, w_win_nxt;
  logic [CW-1:0]    r_cnt, w_eff_cnt, w_cnt_inc;
  logic [NREQ-1:0]  w_win_oh, r_gnt;
  logic             w_any, w_do_grant, w_holder_drop;
  logic             r_valid, r_seed_err;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;

  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], ~^(r_lfsr & TAPS)};

  // While a burst is open the pointer sits on the holder; a holder that
  // dropped its request ends the burst before this cycle's pick.
  assign w_holder_drop = (r_cnt != '0) && !req[r_ptr];
  assign w_eff_ptr = w_holder_drop ?
                     ((r_ptr == IDW'(NREQ - 1)) ? '0 : r_ptr + IDW'(1)) : r_ptr;
  assign w_eff_cnt = w_holder_drop ? '0 : r_cnt;
  assign w_cnt_inc = w_eff_cnt + CW'(1);
  assign w_win_nxt = (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + IDW'(1);

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .i_req    (req),
    .i_ptr    (w_eff_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // Next-state and grant decision; seed_load blocks new grants from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    case (r_state)
      IDLE: begin
        if (seed_load) begin
          w_state_nxt = RESEED;
        end else if (w_any) begin
          w_do_grant  = 1'b1;
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        w_do_grant = w_any;
        if (seed_load)   w_state_nxt = RESEED;
        else if (!w_any) w_state_nxt = IDLE;
      end
      RESEED:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, LFSR, round-robin bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED;
      r_seed_hold <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_id        <= '0;
      r_seed_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= '0;
      r_valid    <= 1'b0;
      r_seed_err <= 1'b0;
      if (seed_load && (r_state != RESEED)) r_seed_hold <= seed_data;
      if (w_do_grant) begin
        r_gnt   <= w_win_oh;
        r_valid <= 1'b1;
        r_data  <= r_lfsr;
        r_id    <= w_win_idx;
        r_lfsr  <= w_lfsr_step;
        if (w_cnt_inc == CW'(BURST)) begin
          r_ptr <= w_win_nxt;
          r_cnt <= '0;
        end else begin
          r_ptr <= w_win_idx;
          r_cnt <= w_cnt_inc;
        end
      end else if (r_state == RESEED) begin
        r_cnt      <= '0;
        r_lfsr     <= (r_seed_hold == LOCKUP) ? SEED : r_seed_hold;
        r_seed_err <= (r_seed_hold == LOCKUP);
      end else begin
        r_ptr <= w_eff_ptr;
        r_cnt <= w_eff_cnt;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rnd_valid = r_valid;
  assign rnd_data  = r_data;
  assign rnd_id    = r_id;
  assign seed_err  = r_seed_err;
  assign busy      = (r_state != IDLE);

`ifdef LFSR_SCHED_STATS_EN
  logic [31:0]           r_draw_count;
  logic [NREQ-1:0][15:0] r_hits;

  // Delivery statistics; only reset clears them, reseeding does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_draw_count <= '0;
      r_hits       <= '0;
    end else if (w_do_grant) begin
      if (r_draw_count != 32'hFFFF_FFFF) r_draw_count <= r_draw_count + 32'd1;
      r_hits[w_win_idx] <= r_hits[w_win_idx] + 16'd1;
    end
  end

  assign draw_count   = r_draw_count;
  assign per_req_hits = r_hits;
`endif

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// tb_lfsr_rr_scheduler: directed scenarios plus randomized traffic against
// a behavioural model; two instances (BURST=4 and BURST=2) share stimulus.
module tb_lfsr_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed_data = 8'h00;
  logic [3:0] req = 4'h0;

  logic [3:0] gnt4, gnt2;
  logic       valid4, valid2, err4, err2, busy4, busy2;
  logic [7:0] data4, data2;
  logic [1:0] id4, id2;
`ifdef LFSR_SCHED_STATS_EN
  logic [31:0]      draw4, draw2;
  logic [3:0][15:0] hits4, hits2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lfsr_rr_scheduler #(.WIDTH(8), .NREQ(4), .BURST(4), .TAPS(8'hB8), .SEED(8'h00)) u_dut4 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_data(seed_data),
    .seed_err(err4), .req(req), .gnt(gnt4), .rnd_valid(valid4),
    .rnd_data(data4), .rnd_id(id4), .busy(busy4)
`ifdef LFSR_SCHED_STATS_EN
    , .draw_count(draw4), .per_req_hits(hits4)
`endif
  );

  lfsr_rr_scheduler #(.WIDTH(8), .NREQ(4), .BURST(2), .TAPS(8'hB8), .SEED(8'h00)) u_dut2 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_data(seed_data),
    .seed_err(err2), .req(req), .gnt(gnt2), .rnd_valid(valid2),
    .rnd_data(data2), .rnd_id(id2), .busy(busy2)
`ifdef LFSR_SCHED_STATS_EN
    , .draw_count(draw2), .per_req_hits(hits2)
`endif
  );

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 serving, 2 reseeding. owner = requester holding an open
  // burst (-1 none), used = words it has had in that burst.
  int         m_mode[2], m_lfsr[2], m_ptr[2], m_owner[2], m_used[2], m_hold[2];
  int         m_start, m_win, m_c;
  logic [3:0] e_gnt[2];
  logic       e_valid[2], e_err[2];
  logic [7:0] e_data[2];
  logic [1:0] e_id[2];
  int         burst_of[2];
  initial begin
    burst_of[0] = 4;
    burst_of[1] = 2;
  end

  function automatic int lfsr_next(int v);
    return ((v << 1) & 8'hFF) | ((($countones(v & 8'hB8) % 2) == 0) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        m_mode[b] = 0; m_lfsr[b] = 0; m_ptr[b] = 0; m_owner[b] = -1;
        m_used[b] = 0; m_hold[b] = 0;
        e_gnt[b] = 4'h0; e_valid[b] = 1'b0; e_err[b] = 1'b0;
        e_data[b] = 8'h00; e_id[b] = 2'd0;
      end else begin
        e_gnt[b] = 4'h0; e_valid[b] = 1'b0; e_err[b] = 1'b0;
        if (m_mode[b] == 2) begin
          if (m_owner[b] >= 0) m_ptr[b] = m_owner[b];
          m_owner[b] = -1; m_used[b] = 0;
          if (m_hold[b] == 255) begin
            m_lfsr[b] = 0; e_err[b] = 1'b1;
          end else begin
            m_lfsr[b] = m_hold[b];
          end
          m_mode[b] = 0;
        end else begin
          if (m_owner[b] >= 0 && !req[m_owner[b]]) begin
            m_ptr[b] = (m_owner[b] + 1) % 4; m_owner[b] = -1; m_used[b] = 0;
          end
          if (seed_load) m_hold[b] = seed_data;
          if (req != 4'h0 && (m_mode[b] == 1 || !seed_load)) begin
            m_start = (m_owner[b] >= 0) ? m_owner[b] : m_ptr[b];
            m_win = -1;
            for (int k = 0; k < 4; k++) begin
              m_c = (m_start + k) % 4;
              if (m_win < 0 && req[m_c]) m_win = m_c;
            end
            e_gnt[b] = 4'(1 << m_win); e_valid[b] = 1'b1;
            e_data[b] = 8'(m_lfsr[b]); e_id[b] = 2'(m_win);
            m_lfsr[b] = lfsr_next(m_lfsr[b]);
            if (m_owner[b] == m_win) m_used[b]++;
            else begin m_owner[b] = m_win; m_used[b] = 1; end
            if (m_used[b] == burst_of[b]) begin
              m_ptr[b] = (m_win + 1) % 4; m_owner[b] = -1; m_used[b] = 0;
            end
            m_mode[b] = seed_load ? 2 : 1;
          end else begin
            m_mode[b] = seed_load ? 2 : 0;
          end
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt4, valid4, data4, id4, err4, busy4} !== 17'h0)
      $display("FAIL reset_outputs4: got %h expected 0", {gnt4, valid4, data4, id4, err4, busy4});
    else n_pass++;
    n_checks++;
    if ({gnt2, valid2, data2, id2, err2, busy2} !== 17'h0)
      $display("FAIL reset_outputs2: got %h expected 0", {gnt2, valid2, data2, id2, err2, busy2});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_req();
    logic [7:0] exp_d [6];
    exp_d = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'b0001 || data4 !== exp_d[k])
        $display("FAIL single_req word %0d: got gnt=%b data=%h expected gnt=0001 data=%h", k, gnt4, data4, exp_d[k]);
      else n_pass++;
      n_checks++;
      if (gnt2 !== 4'b0001 || data2 !== exp_d[k])
        $display("FAIL single_req_b2 word %0d: got gnt=%b data=%h expected gnt=0001 data=%h", k, gnt2, data2, exp_d[k]);
      else n_pass++;
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (valid4 !== 1'b0 || busy4 !== 1'b0)
      $display("FAIL single_req_idle: got valid=%b busy=%b expected 0 0", valid4, busy4);
    else n_pass++;
  endtask

  task automatic test_all_req();
    logic [1:0] exp_b2 [9];
    logic [1:0] exp_b4 [9];
    exp_b2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    exp_b4 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid2 !== 1'b1 || id2 !== exp_b2[k])
        $display("FAIL all_req_b2 word %0d: got valid=%b id=%0d expected 1 %0d", k, valid2, id2, exp_b2[k]);
      else n_pass++;
      n_checks++;
      if (valid4 !== 1'b1 || id4 !== exp_b4[k])
        $display("FAIL all_req_b4 word %0d: got valid=%b id=%0d expected 1 %0d", k, valid4, id4, exp_b4[k]);
      else n_pass++;
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_ptr_drop();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0100;
    repeat (4) @(negedge clk);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (id4 !== 2'd0 || valid4 !== 1'b1)
        $display("FAIL ptr3_wrap word %0d: got id=%0d valid=%b expected id=0 valid=1", k, id4, valid4);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (id4 !== 2'd2 || valid4 !== 1'b1)
      $display("FAIL after_burst: got id=%0d valid=%b expected id=2 valid=1", id4, valid4);
    else n_pass++;
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (id4 !== 2'd0 || gnt4 !== 4'b0001)
      $display("FAIL drop_regrant: got id=%0d gnt=%b expected id=0 gnt=0001", id4, gnt4);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reseed();
    req = 4'b0001;
    @(negedge clk);
    seed_load = 1'b1;
    seed_data = 8'h5A;
    @(negedge clk);
    seed_load = 1'b0;
    n_checks++;
    if (valid4 !== 1'b1 || busy4 !== 1'b1)
      $display("FAIL reseed_finish_grant: got valid=%b busy=%b expected 1 1", valid4, busy4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (valid4 !== 1'b0 || err4 !== 1'b0)
      $display("FAIL reseed_gap: got valid=%b err=%b expected 0 0", valid4, err4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (valid4 !== 1'b1 || data4 !== 8'h5A || data2 !== 8'h5A)
      $display("FAIL reseed_word: got valid=%b data=%h/%h expected 1 5a/5a", valid4, data4, data2);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_bad_seed();
    seed_load = 1'b1;
    seed_data = 8'hFF;
    @(negedge clk);
    seed_load = 1'b0;
    n_checks++;
    if (err4 !== 1'b0)
      $display("FAIL bad_seed_early: got err=%b expected 0", err4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err4 !== 1'b1 || err2 !== 1'b1)
      $display("FAIL bad_seed_pulse: got err=%b/%b expected 1/1", err4, err2);
    else n_pass++;
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (err4 !== 1'b0 || valid4 !== 1'b1 || data4 !== 8'h00 || id4 !== 2'd1)
      $display("FAIL bad_seed_word: got err=%b valid=%b data=%h id=%0d expected 0 1 00 1", err4, valid4, data4, id4);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seed_load = 1'b1;
    seed_data = 8'hFF;
    @(negedge clk);
    n_checks++;
    if ({gnt4, valid4, data4, id4, err4, busy4} !== 17'h0)
      $display("FAIL reset_mid_burst: got %h expected 0", {gnt4, valid4, data4, id4, err4, busy4});
    else n_pass++;
    reset = 1'b0;
    seed_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid4 !== 1'b1 || data4 !== 8'h00 || id4 !== 2'd0 || err4 !== 1'b0)
      $display("FAIL reset_seed_state: got valid=%b data=%h id=%0d err=%b expected 1 00 0 0", valid4, data4, id4, err4);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt4, valid4, data4, id4, err4, busy4} !==
          {e_gnt[0], e_valid[0], e_data[0], e_id[0], e_err[0], (m_mode[0] != 0)})
        $display("FAIL random_b4 cyc %0d: got gnt=%b v=%b d=%h id=%0d err=%b busy=%b expected gnt=%b v=%b d=%h id=%0d err=%b busy=%b",
                 cyc, gnt4, valid4, data4, id4, err4, busy4,
                 e_gnt[0], e_valid[0], e_data[0], e_id[0], e_err[0], (m_mode[0] != 0));
      else n_pass++;
      n_checks++;
      if ({gnt2, valid2, data2, id2, err2, busy2} !==
          {e_gnt[1], e_valid[1], e_data[1], e_id[1], e_err[1], (m_mode[1] != 0)})
        $display("FAIL random_b2 cyc %0d: got gnt=%b v=%b d=%h id=%0d err=%b busy=%b expected gnt=%b v=%b d=%h id=%0d err=%b busy=%b",
                 cyc, gnt2, valid2, data2, id2, err2, busy2,
                 e_gnt[1], e_valid[1], e_data[1], e_id[1], e_err[1], (m_mode[1] != 0));
      else n_pass++;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      seed_load = ($urandom_range(0, 15) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    seed_load = 1'b0;
    req = 4'b0000;
    @(negedge clk);
  endtask

`ifdef LFSR_SCHED_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0010;
    repeat (10) @(negedge clk);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (draw4 !== 32'd13 || hits4[1] !== 16'd10 || hits4[2] !== 16'd3 || hits4[0] !== 16'd0)
      $display("FAIL stats_counts: got draw=%0d hits1=%0d hits2=%0d hits0=%0d expected 13 10 3 0", draw4, hits4[1], hits4[2], hits4[0]);
    else n_pass++;
    seed_load = 1'b1;
    seed_data = 8'h33;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (draw4 !== 32'd13 || hits4[1] !== 16'd10 || hits4[2] !== 16'd3)
      $display("FAIL stats_reseed: got draw=%0d hits1=%0d hits2=%0d expected 13 10 3", draw4, hits4[1], hits4[2]);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_req();
    test_all_req();
    test_ptr_drop();
    test_reseed();
    test_bad_seed();
    test_reset_mid_burst();
    test_random();
`ifdef LFSR_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
